// File: rtl/dpy_arbiter.sv
// rtl/dpy_arbiter.sv - display arbiter: fixed-priority grant with timed message lock (optional dp blink via DPY_ARB_BLINK_EN)
module dpy_arbiter #(
    parameter int unsigned HOLD_CYCLES  = 50_000_000,
    parameter int unsigned BLINK_PERIOD = 12_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req_valid,
    input  logic [31:0] req_number0,
    input  logic [31:0] req_number1,
    input  logic [31:0] req_number2,
    input  logic [7:0]  req_dp0,
    input  logic [7:0]  req_dp1,
    input  logic [7:0]  req_dp2,
    output logic [2:0]  req_ready,
    output logic [31:0] number,
    output logic [7:0]  dp,
    output logic [1:0]  owner,
    output logic        locked
);

    typedef enum logic {
        OPEN = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] hold_cnt;
    logic [31:0] hold_cnt_next;
    logic [2:0]  xfer;
    logic [7:0]  dp_q;

    // Grant: highest valid index wins in OPEN; only the message may pre-empt a lock
    always_comb begin
        req_ready = 3'b000;
        if (rst_n) begin
            if (state == LOCK) begin
                req_ready[2] = req_valid[2];
            end else if (req_valid[2]) begin
                req_ready = 3'b100;
            end else if (req_valid[1]) begin
                req_ready = 3'b010;
            end else if (req_valid[0]) begin
                req_ready = 3'b001;
            end
        end
    end

    assign xfer   = req_valid & req_ready;
    assign locked = (state == LOCK);

    // Next state: a message (re)starts the lock, otherwise the lock runs out after HOLD_CYCLES
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        if (xfer[2]) begin
            state_next    = LOCK;
            hold_cnt_next = 32'd0;
        end else if (state == LOCK) begin
            if (hold_cnt == 32'(HOLD_CYCLES - 1)) begin
                state_next    = OPEN;
                hold_cnt_next = 32'd0;
            end else begin
                hold_cnt_next = hold_cnt + 32'd1;
            end
        end
    end

    // State and hold counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= OPEN;
            hold_cnt <= 32'd0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
        end
    end

    // Display payload latches only on a transfer; the display is never blanked
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            number <= 32'd0;
            dp_q   <= 8'd0;
            owner  <= 2'd0;
        end else if (xfer[2]) begin
            number <= req_number2;
            dp_q   <= req_dp2;
            owner  <= 2'd2;
        end else if (xfer[1]) begin
            number <= req_number1;
            dp_q   <= req_dp1;
            owner  <= 2'd1;
        end else if (xfer[0]) begin
            number <= req_number0;
            dp_q   <= req_dp0;
            owner  <= 2'd0;
        end
    end

`ifdef DPY_ARB_BLINK_EN
    logic [31:0] blink_cnt;
    logic        blink_phase;

    // Blink phase toggles every BLINK_PERIOD cycles of a lock; cleared outside LOCK and on restart
    always_ff @(posedge clk) begin
        if (!rst_n || xfer[2] || state_next != LOCK) begin
            blink_cnt   <= 32'd0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == 32'(BLINK_PERIOD - 1)) begin
            blink_cnt   <= 32'd0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 32'd1;
        end
    end

    assign dp = dp_q | {8{blink_phase}};
`else
    assign dp = dp_q;
`endif

endmodule

// File: tb/tb_dpy_arbiter.sv
// tb/tb_dpy_arbiter.sv - table-driven self-checking bench for dpy_arbiter
module tb_dpy_arbiter;

    localparam logic [31:0] N0 = 32'h0000_0012;
    localparam logic [31:0] N1 = 32'h0000_0059;
    localparam logic [31:0] D1 = 32'hDEAD_0001;
    localparam logic [31:0] B2 = 32'hBEEF_0002;
    localparam logic [7:0]  P0 = 8'h04;
    localparam logic [7:0]  P1 = 8'h02;
    localparam logic [7:0]  P2 = 8'h01;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [31:0] req_number0, req_number1, req_number2;
    logic [7:0]  req_dp0, req_dp1, req_dp2;
    logic [2:0]  req_ready;
    logic [31:0] number;
    logic [7:0]  dp;
    logic [1:0]  owner;
    logic        locked;

    int vec_cnt = 0;
    int miss_cnt = 0;

    typedef struct {
        logic        rst_n;
        logic [2:0]  valid;
        logic [31:0] num2;
        logic [2:0]  exp_ready;
        logic [31:0] exp_number;
        logic [7:0]  exp_dp;
        logic [1:0]  exp_owner;
        logic        exp_locked;
    } vec_t;

    vec_t vecs[$];

    dpy_arbiter #(
        .HOLD_CYCLES (8),
        .BLINK_PERIOD(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_number0(req_number0),
        .req_number1(req_number1),
        .req_number2(req_number2),
        .req_dp0    (req_dp0),
        .req_dp1    (req_dp1),
        .req_dp2    (req_dp2),
        .req_ready  (req_ready),
        .number     (number),
        .dp         (dp),
        .owner      (owner),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    // Expected dp on lock cycle k with stored mask base (blink half-period of 2 cycles)
    function automatic logic [7:0] lock_dp(input logic [7:0] base, input int k);
`ifdef DPY_ARB_BLINK_EN
        return (((k / 2) % 2) == 1) ? (base | 8'hFF) : base;
`else
        return base;
`endif
    endfunction

    function automatic vec_t mk(input logic r, input logic [2:0] v, input logic [31:0] n2,
                                input logic [2:0] er, input logic [31:0] en, input logic [7:0] ed,
                                input logic [1:0] eo, input logic el);
        vec_t t;
        t.rst_n = r;       t.valid = v;        t.num2 = n2;
        t.exp_ready = er;  t.exp_number = en;  t.exp_dp = ed;
        t.exp_owner = eo;  t.exp_locked = el;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, got, exp);
            miss_cnt++;
        end
    endtask

    // Drive one vector after the falling edge, compare just before the next rising edge
    task automatic run_vec(input vec_t t);
        @(negedge clk);
        rst_n       = t.rst_n;
        req_valid   = t.valid;
        req_number2 = t.num2;
        #1;
        check("ready",  vec_cnt, {29'd0, req_ready}, {29'd0, t.exp_ready});
        check("number", vec_cnt, number, t.exp_number);
        check("dp",     vec_cnt, {24'd0, dp}, {24'd0, t.exp_dp});
        check("owner",  vec_cnt, {30'd0, owner}, {30'd0, t.exp_owner});
        check("locked", vec_cnt, {31'd0, locked}, {31'd0, t.exp_locked});
        vec_cnt++;
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 3'b000;
        req_number0 = N0;
        req_number1 = N1;
        req_number2 = D1;
        req_dp0     = P0;
        req_dp1     = P1;
        req_dp2     = P2;

        // Reset with all requesters valid, then the message wins and locks
        vecs.push_back(mk(0, 3'b111, D1, 3'b000, 32'd0, 8'h00, 2'd0, 0));
        vecs.push_back(mk(0, 3'b111, D1, 3'b000, 32'd0, 8'h00, 2'd0, 0));
        vecs.push_back(mk(1, 3'b111, D1, 3'b100, 32'd0, 8'h00, 2'd0, 0));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1, 3'b011, D1, 3'b000, D1, lock_dp(P2, k), 2'd2, 1));
        // Lock over: timer beats score, score starves, then score gets through
        vecs.push_back(mk(1, 3'b011, D1, 3'b010, D1, P2, 2'd2, 0));
        vecs.push_back(mk(1, 3'b011, D1, 3'b010, N1, P1, 2'd1, 0));
        vecs.push_back(mk(1, 3'b001, D1, 3'b001, N1, P1, 2'd1, 0));
        vecs.push_back(mk(1, 3'b000, D1, 3'b000, N0, P0, 2'd0, 0));
        // New lock with a second message colliding with the expiry cycle
        vecs.push_back(mk(1, 3'b100, D1, 3'b100, N0, P0, 2'd0, 0));
        for (int k = 0; k < 7; k++)
            vecs.push_back(mk(1, 3'b000, D1, 3'b000, D1, lock_dp(P2, k), 2'd2, 1));
        vecs.push_back(mk(1, 3'b100, B2, 3'b100, D1, lock_dp(P2, 7), 2'd2, 1));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1, 3'b000, B2, 3'b000, B2, lock_dp(P2, k), 2'd2, 1));
        vecs.push_back(mk(1, 3'b000, B2, 3'b000, B2, P2, 2'd2, 0));

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i]);

        // Reset asserted on lock counter 3 aborts the lock
        run_vec(mk(1, 3'b100, D1, 3'b100, B2, P2, 2'd2, 0));
        for (int k = 0; k < 3; k++)
            run_vec(mk(1, 3'b000, D1, 3'b000, D1, lock_dp(P2, k), 2'd2, 1));
        run_vec(mk(0, 3'b000, D1, 3'b000, D1, lock_dp(P2, 3), 2'd2, 1));
        run_vec(mk(1, 3'b001, D1, 3'b001, 32'd0, 8'h00, 2'd0, 0));
        run_vec(mk(1, 3'b000, D1, 3'b000, N0, P0, 2'd0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/dpy_arbiter.md
DPY_ARBITER -- requirements
Module: dpy_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 50_000_000, which is the message lock duration in clk cycles (legal range 1..2^32-1).
REQ-002 The block SHALL have parameter BLINK_PERIOD, default 12_500_000, which is the half-period of the dp blink in clk cycles (≥1; used only when DPY_ARB_BLINK_EN is defined).
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  3  per-requester valid; bit 0 = score, bit 1 = timer, bit 2 = message.
REQ-006 req_number0, req_number1, req_number2  input  32 each  8-digit hex payload per requester.
REQ-007 req_dp0, req_dp1, req_dp2  input  8 each  decimal-point payload per requester.
REQ-008 req_ready  output  3  per-requester ready; combinational from state and req_valid.
REQ-009 number  output  32  registered value driven to the display scanner.
REQ-010 dp  output  8  registered decimal-point mask driven to the display scanner.
REQ-011 owner  output  2  index of the last accepted requester.
REQ-012 locked  output  1  high while in state LOCK.

Function
REQ-013 The state machine SHALL have exactly two states: OPEN and LOCK.
REQ-014 In OPEN, grant SHALL go by fixed priority 2 > 1 > 0; req_ready[i] = 1 only for the highest-index i with req_valid[i] = 1, and all other bits = 0.
REQ-015 In LOCK, req_ready[2] SHALL equal req_valid[2], and req_ready[1:0] SHALL be 0.
REQ-016 A transfer occurs when req_valid[i] && req_ready[i] on a clk edge; number, dp and owner SHALL take req_numberi, req_dpi and i on that edge (1-cycle latency).
REQ-017 With no transfer, number, dp and owner SHALL hold their values; the display is never blanked by the block.
REQ-018 A transfer from requester 2 SHALL move the FSM to LOCK (from either state) and load hold counter = 0.
REQ-019 In LOCK, the hold counter SHALL increment each cycle; when it equals HOLD_CYCLES-1 with no message transfer, the next state SHALL be OPEN.
REQ-020 A message transfer on the expiry cycle SHALL take priority: the FSM stays in LOCK and the counter restarts at 0.
REQ-021 Transfers from requesters 0 and 1 SHALL NOT change the state.
REQ-022 Requesters SHALL hold valid and payload stable until ready; a payload is sampled only on the transfer edge.
REQ-023 Starvation of lower-priority requesters under continuous higher-priority traffic is accepted behaviour.

Reset
REQ-024 With rst_n = 0 at a clk edge, the block SHALL set state = OPEN, number = 0, dp = 0, owner = 0, and clear the hold counter and blink counter.
REQ-025 While rst_n = 0, req_ready SHALL be 3'b000.
REQ-026 Reset asserted mid-LOCK SHALL abort the lock; the first cycle after release is OPEN with normal arbitration.

Configuration
REQ-027 Macro DPY_ARB_BLINK_EN defined: in LOCK, a blink counter SHALL toggle a blink phase every BLINK_PERIOD cycles, starting with phase 0 at LOCK entry or restart.
REQ-028 With DPY_ARB_BLINK_EN defined, in phase 1 the dp output SHALL be the stored dp OR 8'hFF; in phase 0, and in OPEN, it SHALL be the stored dp.
REQ-029 With DPY_ARB_BLINK_EN undefined, there SHALL be no blink logic, dp SHALL always equal the stored dp, and BLINK_PERIOD SHALL be ignored.

Verification (HOLD_CYCLES=8, BLINK_PERIOD=2 for the bench)
REQ-030 Reset: rst_n=0 for 2 cycles with all valid high -> number=0, dp=0, owner=0, locked=0, req_ready=000; after release, req_ready=100.
REQ-031 Priority: valid=011, num0=32'h00000012, num1=32'h00000059 -> ready=010; next cycle number=32'h00000059, owner=1; score still waiting.
REQ-032 Lock: message 32'hDEAD0001 accepted -> locked=1 for exactly 8 cycles, ready=000 with valid=011 throughout; on the 9th cycle ready=010 and locked=0.
REQ-033 Expiry collision: a second message 32'hBEEF0002 presented on counter=7 -> accepted; locked stays 1 for 8 further cycles; number=32'hBEEF0002.
REQ-034 Reset mid-LOCK: rst_n=0 at counter=3 -> next cycle locked=0, number=0; valid=001 after release -> number=req_number0 one cycle later.
REQ-035 Blink (macro defined): stored dp=8'h01 in LOCK -> dp sequence 01,01,FF,FF,01,01,FF,FF; with the macro undefined -> dp constant 01.
